rd_axi_master: RTL and testbench
================================

RD_AXI_MASTER -- requirements
Module: rd_axi_master

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 128, AXI data width; legal values are 32/64/128/256.
REQ-003 SHALL have parameter FIFO_DEPTH, default 512, read-data FIFO depth; power of two, at least 256.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  reset, asynchronous, active-high.
REQ-006 rd_req_en  in  1  request valid from the read-control stage.
REQ-007 rd_addr_out  in  AXI_ADDR_WIDTH  burst start byte address; qualified by rd_req_en.
REQ-008 rd_burst_length  in  8  beats-1; qualified by rd_req_en.
REQ-009 rd_buffer_ready  out  1  request accept; handshake completes when rd_req_en && rd_buffer_ready.
REQ-010 m_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arqos/arvalid  out  4/AXI_ADDR_WIDTH/8/3/2/1/4/3/4/1  AXI4 AR channel.
REQ-011 m_axi_arready  in  1  AXI4 AR ready.
REQ-012 m_axi_rid/rdata/rresp/rlast/rvalid  in  4/AXI_DATA_WIDTH/2/1/1  AXI4 R channel.
REQ-013 m_axi_rready  out  1  AXI4 R ready.
REQ-014 rd_data  out  AXI_DATA_WIDTH  read data to user, FIFO head.
REQ-015 rd_data_valid  out  1  FIFO not empty.
REQ-016 rd_data_ready  in  1  user pop; pop occurs when rd_data_valid && rd_data_ready.
REQ-017 rd_done  out  1  one-cycle pulse at burst completion.
REQ-018 rd_err  out  1  one-cycle pulse on protocol/response error.

Function
REQ-019 FSM SHALL have states IDLE, ADDR, DATA, DONE: IDLE->ADDR on request handshake; ADDR->DATA on arvalid&&arready; DATA->DONE on accepted beat with rlast; DONE->IDLE unconditionally.
REQ-020 rd_buffer_ready SHALL be registered-state-derived only: high iff state==IDLE and FIFO free entries >= 256; never combinationally dependent on rd_req_en.
REQ-021 On handshake, address and length SHALL be captured; araddr=captured address, arlen=captured length, arsize=log2(AXI_DATA_WIDTH/8), arburst=2'b01, arid=0, arlock=0, arcache=4'b0011, arprot=0, arqos=0.
REQ-022 m_axi_arvalid SHALL be high exactly in ADDR; all AR fields SHALL stay stable while arvalid && !arready.
REQ-023 m_axi_rready SHALL be high exactly in DATA; FIFO space is guaranteed by REQ-020.
REQ-024 Every accepted R beat with beat index <= arlen SHALL be pushed to the FIFO in arrival order; beats beyond index arlen SHALL be dropped.
REQ-025 The beat counter SHALL be 9 bits, cleared on entering DATA, and incremented per accepted beat.
REQ-026 rd_err SHALL pulse (one cycle, at the beat) when rresp != 2'b00, when rlast arrives at index < arlen (burst ends early), or when index == arlen without rlast (burst continues until rlast, extra beats dropped, one pulse).
REQ-027 rd_done SHALL be high for exactly the DONE cycle; latency from the last beat to rd_done is 1 cycle.
REQ-028 Minimum request-to-request spacing SHALL be 4 cycles (IDLE, ADDR, DATA, DONE).
REQ-029 FIFO push and pop in the same cycle SHALL both occur; a pop when empty SHALL be ignored; a push when full is unreachable and SHALL be covered by an assertion.
REQ-030 The FIFO SHALL be first-word-fall-through: rd_data is valid in the same cycle rd_data_valid is high.

Reset
REQ-031 On reset assertion, the block SHALL immediately set: state=IDLE; arvalid, rready, rd_done, rd_err, rd_buffer_ready = 0; FIFO emptied so rd_data_valid = 0; beat counter = 0; captured address/length = 0.
REQ-032 A reset during ADDR or DATA SHALL abandon the transaction; the AXI slave SHALL share the same reset. rd_buffer_ready SHALL rise no earlier than the first clock after reset deassertion.

Structure
REQ-033 AXI constants SHALL live in a shared package: BURST_INCR=2'b01, RESP_OKAY=2'b00, CACHE_DEFAULT=4'b0011, and the state encoding (one-hot, 4 bits).
REQ-034 The FIFO SHALL be one sub-module, sync_fifo_fwft (parameters width, depth; outputs full, empty, free count); everything else SHALL be inline.

Verification
REQ-035 Request addr 0x1000, len 0xFF; arready immediate; rvalid every cycle -> araddr=0x1000, arlen=0xFF, arsize=3'b100; 256 beats in order; one rd_done; rd_err never pulses.
REQ-036 rd_data_ready held low; two 256-beat requests -> the second handshake is withheld until >=256 entries are popped; no data lost or duplicated.
REQ-037 arready delayed 5 cycles -> arvalid held for 6 cycles with AR fields stable; rready stays low until after the AR handshake.
REQ-038 rresp=SLVERR on beat 3 of len 7 -> one rd_err pulse on that beat; all 8 beats are pushed; rd_done pulses.
REQ-039 len 15 with rlast on beat 9 -> rd_err pulse, 10 beats pushed, return to IDLE; a following request completes normally.
REQ-040 Reset asserted at beat 50 of 256 -> all outputs at reset values in the same cycle; FIFO empty; the next request after reset completes correctly.

Source files
------------

// File: rtl/rd_axi_master_pkg.sv
// Shared AXI read-master constants and FSM encoding.
package rd_axi_master_pkg;

  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

  // Largest burst is 256 beats, so this much free space guarantees rready.
  localparam int unsigned MIN_FREE = 256;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_ADDR = 4'b0010,
    S_DATA = 4'b0100,
    S_DONE = 4'b1000
  } state_e;

  function automatic logic [2:0] axi_size(input int unsigned dw);
    return 3'($clog2(dw / 8));
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO.
module sync_fifo_fwft #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 512,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      free_cnt
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign free_cnt = (AW+1)'(DEPTH) - cnt_q;
  assign dout     = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/rd_axi_master.sv
// AXI4 read master: one INCR burst per request, data
// buffered in a FWFT FIFO toward the user.
module rd_axi_master
  import rd_axi_master_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 128,
  parameter int FIFO_DEPTH     = 512
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rd_req_en,
  input  logic [AXI_ADDR_WIDTH-1:0] rd_addr_out,
  input  logic [7:0]                rd_burst_length,
  output logic                      rd_buffer_ready,
  output logic [3:0]                m_axi_arid,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                m_axi_arlen,
  output logic [2:0]                m_axi_arsize,
  output logic [1:0]                m_axi_arburst,
  output logic                      m_axi_arlock,
  output logic [3:0]                m_axi_arcache,
  output logic [2:0]                m_axi_arprot,
  output logic [3:0]                m_axi_arqos,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [3:0]                m_axi_rid,
  input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rlast,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  output logic [AXI_DATA_WIDTH-1:0] rd_data,
  output logic                      rd_data_valid,
  input  logic                      rd_data_ready,
  output logic                      rd_done,
  output logic                      rd_err
);

  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam logic [2:0] AR_SIZE = axi_size(AXI_DATA_WIDTH);

  state_e                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]                len_q, len_d;
  logic [8:0]                beat_q, beat_d;
  logic                      live_q, live_d;
  logic [FAW:0]              fifo_free;
  logic                      fifo_full, fifo_empty;
  logic                      req_hs, r_hs, push, pop;
  logic [8:0]                len_ext;
  logic [3:0]                unused_rid;

  assign unused_rid = m_axi_rid;
  assign len_ext    = {1'b0, len_q};

  // live_q keeps the accept low until one clock after reset release.
  assign rd_buffer_ready = live_q && (state_q == S_IDLE)
                        && (fifo_free >= (FAW+1)'(MIN_FREE));
  assign req_hs = rd_req_en && rd_buffer_ready;

  assign m_axi_arid    = '0;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = AR_SIZE;
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = CACHE_DEFAULT;
  assign m_axi_arprot  = '0;
  assign m_axi_arqos   = '0;
  assign m_axi_arvalid = (state_q == S_ADDR);
  assign m_axi_rready  = (state_q == S_DATA);

  assign r_hs = m_axi_rvalid && m_axi_rready;
  assign push = r_hs && (beat_q <= len_ext);
  assign pop  = rd_data_ready;

  assign rd_err = r_hs && ((m_axi_rresp != RESP_OKAY)
               || (m_axi_rlast && (beat_q < len_ext))
               || (!m_axi_rlast && (beat_q == len_ext)));
  assign rd_done       = (state_q == S_DONE);
  assign rd_data_valid = !fifo_empty;
  assign live_d        = 1'b1;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (req_hs) begin
          state_d = S_ADDR;
          addr_d  = rd_addr_out;
          len_d   = rd_burst_length;
        end
      end
      (state_q == S_ADDR): begin
        if (m_axi_arready) begin
          state_d = S_DATA;
          beat_d  = '0;
        end
      end
      (state_q == S_DATA): begin
        if (r_hs) begin
          // Saturate so a runaway slave can never wrap back into range.
          if (beat_q != 9'h1FF) beat_d = beat_q + 1'b1;
          if (m_axi_rlast) state_d = S_DONE;
        end
      end
      (state_q == S_DONE): state_d = S_IDLE;
      default:             state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      live_q  <= live_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (AXI_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (reset),
    .push     (push),
    .din      (m_axi_rdata),
    .pop      (pop),
    .dout     (rd_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .free_cnt (fifo_free)
  );

  a_no_push_full: assert property (
    @(posedge clk) disable iff (reset) !(push && fifo_full));

endmodule

// File: tb/tb_rd_axi_master.sv
// Directed self-checking bench for rd_axi_master.
`timescale 1ns/1ps
module tb_rd_axi_master;

  localparam int AW    = 32;
  localparam int DW    = 128;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          reset;
  logic          rd_req_en;
  logic [AW-1:0] rd_addr_out;
  logic [7:0]    rd_burst_length;
  logic          rd_buffer_ready;
  logic [3:0]    m_axi_arid;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arlock;
  logic [3:0]    m_axi_arcache;
  logic [2:0]    m_axi_arprot;
  logic [3:0]    m_axi_arqos;
  logic          m_axi_arvalid;
  logic          m_axi_arready;
  logic [3:0]    m_axi_rid;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast;
  logic          m_axi_rvalid;
  logic          m_axi_rready;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic          rd_data_ready;
  logic          rd_done;
  logic          rd_err;

  int checks = 0;
  int errors = 0;
  int err_cnt, done_cnt, arv_cnt, err_at;
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_q[$];

  rd_axi_master #(
    .AXI_ADDR_WIDTH (AW),
    .AXI_DATA_WIDTH (DW),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .rd_req_en       (rd_req_en),
    .rd_addr_out     (rd_addr_out),
    .rd_burst_length (rd_burst_length),
    .rd_buffer_ready (rd_buffer_ready),
    .m_axi_arid      (m_axi_arid),
    .m_axi_araddr    (m_axi_araddr),
    .m_axi_arlen     (m_axi_arlen),
    .m_axi_arsize    (m_axi_arsize),
    .m_axi_arburst   (m_axi_arburst),
    .m_axi_arlock    (m_axi_arlock),
    .m_axi_arcache   (m_axi_arcache),
    .m_axi_arprot    (m_axi_arprot),
    .m_axi_arqos     (m_axi_arqos),
    .m_axi_arvalid   (m_axi_arvalid),
    .m_axi_arready   (m_axi_arready),
    .m_axi_rid       (m_axi_rid),
    .m_axi_rdata     (m_axi_rdata),
    .m_axi_rresp     (m_axi_rresp),
    .m_axi_rlast     (m_axi_rlast),
    .m_axi_rvalid    (m_axi_rvalid),
    .m_axi_rready    (m_axi_rready),
    .rd_data         (rd_data),
    .rd_data_valid   (rd_data_valid),
    .rd_data_ready   (rd_data_ready),
    .rd_done         (rd_done),
    .rd_err          (rd_err)
  );

  always #5 clk = ~clk;

  // Observe on the falling edge; inputs only change just after rising edges.
  always @(negedge clk) begin
    if (!reset) begin
      if (rd_data_valid && rd_data_ready) got_q.push_back(rd_data);
      if (rd_err) begin
        err_cnt++;
        err_at = int'(m_axi_rdata[31:0]);
      end
      if (rd_done) done_cnt++;
      if (m_axi_arvalid) arv_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] bd(input logic [31:0] tag, input int i);
    return {tag, 64'h0, 32'(i)};
  endfunction

  task automatic clear_counts();
    err_cnt  = 0;
    done_cnt = 0;
    arv_cnt  = 0;
    err_at   = -1;
  endtask

  task automatic request(input logic [31:0] a, input logic [7:0] l);
    int n = 0;
    rd_req_en       = 1'b1;
    rd_addr_out     = a;
    rd_burst_length = l;
    while (!rd_buffer_ready && n < 1000) begin
      step();
      n++;
    end
    chk("req_accept_timeout", 128'(n < 1000), 128'(1));
    step();
    rd_req_en = 1'b0;
  endtask

  task automatic ar_phase(input int delay, input logic [31:0] a,
                          input logic [7:0] l);
    for (int d = 0; d < delay; d++) begin
      chk("ar_hold_valid", m_axi_arvalid, 1'b1);
      chk("ar_hold_addr", m_axi_araddr, a);
      chk("ar_hold_len", m_axi_arlen, l);
      chk("rready_before_ar", m_axi_rready, 1'b0);
      step();
    end
    m_axi_arready = 1'b1;
    step();
    m_axi_arready = 1'b0;
  endtask

  task automatic r_burst(input logic [31:0] tag, input int n,
                         input int last_i, input int err_i, input int len);
    chk("rready_in_data", m_axi_rready, 1'b1);
    for (int i = 0; i < n; i++) begin
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = bd(tag, i);
      m_axi_rresp  = (i == err_i) ? 2'b10 : 2'b00;
      m_axi_rlast  = (i == last_i);
      if (i <= len) exp_q.push_back(bd(tag, i));
      step();
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    m_axi_rresp  = 2'b00;
  endtask

  task automatic compare_data(input string tag);
    int bad = 0;
    chk({tag, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) bad++;
    chk({tag, "_order"}, 128'(bad), 128'(0));
  endtask

  initial begin
    reset           = 1'b1;
    rd_req_en       = 1'b0;
    rd_addr_out     = '0;
    rd_burst_length = '0;
    m_axi_arready   = 1'b0;
    m_axi_rid       = '0;
    m_axi_rdata     = '0;
    m_axi_rresp     = 2'b00;
    m_axi_rlast     = 1'b0;
    m_axi_rvalid    = 1'b0;
    rd_data_ready   = 1'b0;
    clear_counts();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_buf_ready", rd_buffer_ready, 1'b0);
    chk("rst_arvalid", m_axi_arvalid, 1'b0);
    chk("rst_rready", m_axi_rready, 1'b0);
    chk("rst_data_valid", rd_data_valid, 1'b0);
    chk("rst_done", rd_done, 1'b0);
    chk("rst_err", rd_err, 1'b0);
    reset = 1'b0;
    #1;
    chk("ready_at_release", rd_buffer_ready, 1'b0);
    step();
    chk("ready_after_release", rd_buffer_ready, 1'b1);

    // 256-beat burst, immediate arready, continuous data
    rd_data_ready = 1'b1;
    clear_counts();
    request(32'h1000, 8'hFF);
    chk("araddr", m_axi_araddr, 32'h1000);
    chk("arlen", m_axi_arlen, 8'hFF);
    chk("arsize", m_axi_arsize, 3'b100);
    chk("arburst", m_axi_arburst, 2'b01);
    chk("arcache", m_axi_arcache, 4'b0011);
    chk("arid", m_axi_arid, 4'h0);
    chk("arlock", m_axi_arlock, 1'b0);
    chk("arprot", m_axi_arprot, 3'h0);
    chk("arqos", m_axi_arqos, 4'h0);
    chk("arvalid_in_addr", m_axi_arvalid, 1'b1);
    ar_phase(0, 32'h1000, 8'hFF);
    r_burst(32'h1, 256, 255, -1, 255);
    chk("done_after_last", rd_done, 1'b1);
    repeat (3) step();
    compare_data("full_burst");
    chk("full_done_cnt", 128'(done_cnt), 128'(1));
    chk("full_err_cnt", 128'(err_cnt), 128'(0));

    // arready held off for 5 cycles
    got_q.delete();
    exp_q.delete();
    clear_counts();
    request(32'h2000, 8'd3);
    ar_phase(5, 32'h2000, 8'd3);
    chk("arvalid_cycles", 128'(arv_cnt), 128'(6));
    chk("arvalid_dropped", m_axi_arvalid, 1'b0);
    r_burst(32'h2, 4, 3, -1, 3);
    repeat (3) step();
    compare_data("ar_delay");
    chk("ar_delay_done", 128'(done_cnt), 128'(1));

    // SLVERR on beat 3 of 8
    got_q.delete();
    exp_q.delete();
    clear_counts();
    request(32'h3000, 8'd7);
    ar_phase(0, 32'h3000, 8'd7);
    r_burst(32'h3, 8, 7, 3, 7);
    chk("slverr_done", rd_done, 1'b1);
    repeat (3) step();
    chk("slverr_err_cnt", 128'(err_cnt), 128'(1));
    chk("slverr_err_beat", 128'(err_at), 128'(3));
    chk("slverr_done_cnt", 128'(done_cnt), 128'(1));
    compare_data("slverr");

    // early rlast: len 15, rlast on beat 9
    got_q.delete();
    exp_q.delete();
    clear_counts();
    request(32'h4000, 8'd15);
    ar_phase(0, 32'h4000, 8'd15);
    r_burst(32'h4, 10, 9, -1, 15);
    step();
    chk("early_idle_ready", rd_buffer_ready, 1'b1);
    chk("early_err_cnt", 128'(err_cnt), 128'(1));
    chk("early_err_beat", 128'(err_at), 128'(9));
    chk("early_done_cnt", 128'(done_cnt), 128'(1));
    repeat (2) step();
    compare_data("early_last");
    clear_counts();
    request(32'h5000, 8'd1);
    ar_phase(0, 32'h5000, 8'd1);
    r_burst(32'h5, 2, 1, -1, 1);
    repeat (3) step();
    chk("after_early_err", 128'(err_cnt), 128'(0));
    chk("after_early_done", 128'(done_cnt), 128'(1));
    compare_data("after_early");

    // reset at beat 50 of a 256-beat burst
    got_q.delete();
    exp_q.delete();
    clear_counts();
    rd_data_ready = 1'b0;
    request(32'h6000, 8'hFF);
    ar_phase(0, 32'h6000, 8'hFF);
    r_burst(32'h6, 50, -1, -1, 255);
    chk("mid_fifo_valid", rd_data_valid, 1'b1);
    chk("mid_rready", m_axi_rready, 1'b1);
    reset        = 1'b1;
    m_axi_rvalid = 1'b1;
    #1;
    chk("mid_rst_arvalid", m_axi_arvalid, 1'b0);
    chk("mid_rst_rready", m_axi_rready, 1'b0);
    chk("mid_rst_valid", rd_data_valid, 1'b0);
    chk("mid_rst_buf_ready", rd_buffer_ready, 1'b0);
    chk("mid_rst_done", rd_done, 1'b0);
    chk("mid_rst_err", rd_err, 1'b0);
    m_axi_rvalid = 1'b0;
    step();
    reset = 1'b0;
    got_q.delete();
    exp_q.delete();
    clear_counts();
    step();
    rd_data_ready = 1'b1;
    request(32'h7000, 8'd3);
    chk("post_rst_araddr", m_axi_araddr, 32'h7000);
    ar_phase(0, 32'h7000, 8'd3);
    r_burst(32'h7, 4, 3, -1, 3);
    repeat (3) step();
    compare_data("post_rst");
    chk("post_rst_done", 128'(done_cnt), 128'(1));

    // back-pressure: full FIFO withholds the next request
    got_q.delete();
    exp_q.delete();
    clear_counts();
    rd_data_ready = 1'b0;
    request(32'h8000, 8'hFF);
    ar_phase(0, 32'h8000, 8'hFF);
    r_burst(32'h8, 256, 255, -1, 255);
    step();
    chk("bp_ready_low", rd_buffer_ready, 1'b0);
    rd_req_en       = 1'b1;
    rd_addr_out     = 32'h9000;
    rd_burst_length = 8'hFF;
    repeat (10) step();
    chk("bp_withheld_ready", rd_buffer_ready, 1'b0);
    chk("bp_withheld_arvalid", m_axi_arvalid, 1'b0);
    chk("bp_no_pops", 128'(got_q.size()), 128'(0));
    rd_data_ready = 1'b1;
    request(32'h9000, 8'hFF);
    chk("bp_pops_before_accept", 128'(got_q.size()), 128'(256));
    chk("bp_second_araddr", m_axi_araddr, 32'h9000);
    ar_phase(0, 32'h9000, 8'hFF);
    r_burst(32'h9, 256, 255, -1, 255);
    repeat (3) step();
    compare_data("bp");
    chk("bp_done_cnt", 128'(done_cnt), 128'(2));
    chk("bp_err_cnt", 128'(err_cnt), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
